// File: rtl/audio_post_mix_if.sv
// audio_post_mix_if: source strobe/levels in, filtered PCM and strobe out.
// master drives the sources, slave is the post-mix stage.
interface audio_post_mix_if;
  logic               ce_in;
  logic        [15:0] tia_aud;
  logic        [15:0] pokey_aud;
  logic        [15:0] ym_l;
  logic        [15:0] ym_r;
  logic               mute;
  logic signed [15:0] audio_l;
  logic signed [15:0] audio_r;
  logic               sample_valid;

  modport master (
    output ce_in, tia_aud, pokey_aud,
    output ym_l, ym_r, mute,
    input  audio_l, audio_r, sample_valid
  );

  modport slave (
    input  ce_in, tia_aud, pokey_aud,
    input  ym_l, ym_r, mute,
    output audio_l, audio_r, sample_valid
  );
endinterface

// File: rtl/audio_post_mix.sv
// audio_post_mix: saturating mix, signed PCM, one-pole LPF, decimator.
// Define AUDIO_POST_MIX_DCBLOCK_EN to turn S4 into a DC blocker.
module audio_post_mix #(
  parameter int LPF_SHIFT = 4,
  parameter int DECIM     = 16,
  parameter int DC_SHIFT  = 9
) (
  input logic             clk_sys,
  input logic             reset_n,
  audio_post_mix_if.slave bus
);

  localparam logic [7:0] CNT_TOP = 8'(DECIM - 1);

  function automatic logic [17:0] mix(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [15:0] c,
    input logic        m
  );
    return m ? 18'h08000
             : 18'(a) + 18'(b) + 18'(c);
  endfunction

  function automatic logic signed [15:0] to_pcm(
    input logic [17:0] s
  );
    logic [15:0] sat;
    sat = (s > 18'h0FFFF) ? 16'hFFFF : s[15:0];
    return {~sat[15], sat[14:0]};
  endfunction

  // Step is floored; |step| <= |pcm - lp| so lp stays in range.
  function automatic logic signed [15:0] iir(
    input logic signed [15:0] lp,
    input logic signed [15:0] pcm
  );
    logic signed [16:0] d;
    d = (17'(pcm) - 17'(lp)) >>> LPF_SHIFT;
    return lp + d[15:0];
  endfunction

  logic               v1_q, v1_d;
  logic               v2_q, v2_d;
  logic               v3_q, v3_d;
  logic               v4_q, v4_d;
  logic        [17:0] sum_l_q, sum_l_d;
  logic        [17:0] sum_r_q, sum_r_d;
  logic signed [15:0] pcm_l_q, pcm_l_d;
  logic signed [15:0] pcm_r_q, pcm_r_d;
  logic signed [15:0] lp_l_q, lp_l_d;
  logic signed [15:0] lp_r_q, lp_r_d;
  logic signed [15:0] out_l, out_r;
  logic signed [15:0] aud_l_q, aud_l_d;
  logic signed [15:0] aud_r_q, aud_r_d;
  logic         [7:0] cnt_q, cnt_d;
  logic               vld_q, vld_d;

  always_comb begin
    v1_d    = bus.ce_in;
    v2_d    = v1_q;
    v3_d    = v2_q;
    v4_d    = v3_q;
    sum_l_d = sum_l_q;
    sum_r_d = sum_r_q;
    pcm_l_d = pcm_l_q;
    pcm_r_d = pcm_r_q;
    lp_l_d  = lp_l_q;
    lp_r_d  = lp_r_q;
    if (bus.ce_in) begin
      sum_l_d = mix(bus.tia_aud, bus.pokey_aud,
                    bus.ym_l, bus.mute);
      sum_r_d = mix(bus.tia_aud, bus.pokey_aud,
                    bus.ym_r, bus.mute);
    end
    if (v1_q) begin
      pcm_l_d = to_pcm(sum_l_q);
      pcm_r_d = to_pcm(sum_r_q);
    end
    if (v2_q) begin
      lp_l_d = iir(lp_l_q, pcm_l_q);
      lp_r_d = iir(lp_r_q, pcm_r_q);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      v4_q    <= 1'b0;
      sum_l_q <= '0;
      sum_r_q <= '0;
      pcm_l_q <= '0;
      pcm_r_q <= '0;
      lp_l_q  <= '0;
      lp_r_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      v4_q    <= v4_d;
      sum_l_q <= sum_l_d;
      sum_r_q <= sum_r_d;
      pcm_l_q <= pcm_l_d;
      pcm_r_q <= pcm_r_d;
      lp_l_q  <= lp_l_d;
      lp_r_q  <= lp_r_d;
    end
  end

`ifdef AUDIO_POST_MIX_DCBLOCK_EN
  function automatic logic signed [16:0] dcb(
    input logic signed [15:0] lp,
    input logic signed [15:0] lpp,
    input logic signed [16:0] y
  );
    logic signed [18:0] t;
    t = 19'(lp) - 19'(lpp) + 19'(y)
      - 19'(y >>> DC_SHIFT);
    if (t > 19'sd32767) return 17'sd32767;
    if (t < -19'sd32768) return -17'sd32768;
    return t[16:0];
  endfunction

  logic signed [15:0] lpp_l_q, lpp_l_d;
  logic signed [15:0] lpp_r_q, lpp_r_d;
  logic signed [16:0] y_l_q, y_l_d;
  logic signed [16:0] y_r_q, y_r_d;

  always_comb begin
    lpp_l_d = lpp_l_q;
    lpp_r_d = lpp_r_q;
    y_l_d   = y_l_q;
    y_r_d   = y_r_q;
    if (v3_q) begin
      y_l_d   = dcb(lp_l_q, lpp_l_q, y_l_q);
      y_r_d   = dcb(lp_r_q, lpp_r_q, y_r_q);
      lpp_l_d = lp_l_q;
      lpp_r_d = lp_r_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lpp_l_q <= '0;
      lpp_r_q <= '0;
      y_l_q   <= '0;
      y_r_q   <= '0;
    end else begin
      lpp_l_q <= lpp_l_d;
      lpp_r_q <= lpp_r_d;
      y_l_q   <= y_l_d;
      y_r_q   <= y_r_d;
    end
  end

  assign out_l = y_l_q[15:0];
  assign out_r = y_r_q[15:0];
`else
  logic signed [15:0] out_l_q, out_l_d;
  logic signed [15:0] out_r_q, out_r_d;

  always_comb begin
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    if (v3_q) begin
      out_l_d = lp_l_q;
      out_r_d = lp_r_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      out_l_q <= '0;
      out_r_q <= '0;
    end else begin
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
    end
  end

  assign out_l = out_l_q;
  assign out_r = out_r_q;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    aud_l_d = aud_l_q;
    aud_r_d = aud_r_q;
    vld_d   = 1'b0;
    if (v4_q) begin
      if (cnt_q == CNT_TOP) begin
        cnt_d   = '0;
        aud_l_d = out_l;
        aud_r_d = out_r;
        vld_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      aud_l_q <= '0;
      aud_r_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      aud_l_q <= aud_l_d;
      aud_r_q <= aud_r_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.audio_l      = aud_l_q;
  assign bus.audio_r      = aud_r_q;
  assign bus.sample_valid = vld_q;

endmodule

// File: tb/tb_audio_post_mix.sv
// tb_audio_post_mix: DECIM=1 and DECIM=16 instances fed in parallel,
// outputs checked against an arithmetic model of the mix/filter chain.
module tb_audio_post_mix;

  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  audio_post_mix_if b1 ();
  audio_post_mix_if b16 ();

  assign b16.ce_in     = b1.ce_in;
  assign b16.tia_aud   = b1.tia_aud;
  assign b16.pokey_aud = b1.pokey_aud;
  assign b16.ym_l      = b1.ym_l;
  assign b16.ym_r      = b1.ym_r;
  assign b16.mute      = b1.mute;

  audio_post_mix #(
    .LPF_SHIFT(4), .DECIM(1), .DC_SHIFT(9)
  ) u_d1 (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(b1.slave)
  );

  audio_post_mix #(
    .LPF_SHIFT(4), .DECIM(16), .DC_SHIFT(9)
  ) u_d16 (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(b16.slave)
  );

  typedef struct {
    int l;
    int r;
  } smp_t;

  int   errors = 0;
  int   checks = 0;
  int   n1 = 0;
  int   n16 = 0;
  logic prev16 = 1'b0;
  int   m_lp [2];
  int   m_lpp[2];
  int   m_y  [2];
  int   m_cnt;
  smp_t q1[$];
  smp_t q16[$];

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int fdiv(input int a, input int sh);
    int p;
    int r;
    p = 1 << sh;
    r = a % p;
    if (r < 0) r += p;
    return (a - r) / p;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_lp[c]  = 0;
      m_lpp[c] = 0;
      m_y[c]   = 0;
    end
    m_cnt = 0;
    q1.delete();
    q16.delete();
  endfunction

  function automatic void model_step(
    input int t, input int p,
    input int yl, input int yr, input bit m);
    int   s;
    int   pcm;
    int   y;
    int   o[2];
    smp_t e;
    if (reset_n !== 1'b1) return;
    for (int c = 0; c < 2; c++) begin
      s = m ? 32768 : t + p + (c == 0 ? yl : yr);
      if (s > 65535) s = 65535;
      pcm = s - 32768;
      m_lp[c] = m_lp[c] + fdiv(pcm - m_lp[c], 4);
`ifdef AUDIO_POST_MIX_DCBLOCK_EN
      y = m_lp[c] - m_lpp[c] + m_y[c] - fdiv(m_y[c], 9);
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      m_lpp[c] = m_lp[c];
      m_y[c]   = y;
      o[c]     = y;
`else
      y    = m_lp[c];
      o[c] = y;
`endif
    end
    e.l = o[0];
    e.r = o[1];
    q1.push_back(e);
    m_cnt++;
    if (m_cnt == 16) begin
      m_cnt = 0;
      q16.push_back(e);
    end
  endfunction

  task automatic strobe(input logic [15:0] t,
                        input logic [15:0] p,
                        input logic [15:0] yl,
                        input logic [15:0] yr,
                        input logic m);
    b1.tia_aud   = t;
    b1.pokey_aud = p;
    b1.ym_l      = yl;
    b1.ym_r      = yr;
    b1.mute      = m;
    b1.ce_in     = 1'b1;
    model_step(int'(t), int'(p), int'(yl), int'(yr), m);
    @(posedge clk_sys);
    #1;
    b1.ce_in = 1'b0;
  endtask

  task automatic rnd_strobe(input logic m);
    strobe(16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), m);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  always @(negedge clk_sys) begin
    smp_t e;
    if (reset_n !== 1'b1) begin
      chk("rst_sv1", int'(b1.sample_valid), 0);
      chk("rst_sv16", int'(b16.sample_valid), 0);
    end
    if (b1.sample_valid === 1'b1) begin
      n1++;
      chk("d1_pending", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_l", int'(b1.audio_l), e.l);
        chk("d1_r", int'(b1.audio_r), e.r);
      end
    end
    if (b16.sample_valid === 1'b1) begin
      n16++;
      chk("d16_width", int'(prev16), 0);
      chk("d16_pending", int'(q16.size() > 0), 1);
      if (q16.size() > 0) begin
        e = q16.pop_front();
        chk("d16_l", int'(b16.audio_l), e.l);
        chk("d16_r", int'(b16.audio_r), e.r);
      end
    end
    prev16 = b16.sample_valid;
  end

  initial begin
    int prev;
    int base;
    int d;
    reset_n      = 1'b0;
    b1.ce_in     = 1'b0;
    b1.tia_aud   = '0;
    b1.pokey_aud = '0;
    b1.ym_l      = '0;
    b1.ym_r      = '0;
    b1.mute      = 1'b0;
    model_reset();
    idle(2);

    // strobes during reset are ignored
    for (int i = 0; i < 3; i++) rnd_strobe(1'b0);
    idle(6);
    chk("rst_l", int'(b1.audio_l), 0);
    chk("rst_r", int'(b1.audio_r), 0);
    chk("rst_l16", int'(b16.audio_l), 0);
    chk("rst_n1", n1, 0);
    reset_n = 1'b1;
    idle(2);

    // saturation and output latency
    strobe(16'h7FFF, 16'h7FFF, 16'h2000, 16'h0000, 1'b0);
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("lat_early", int'(b1.sample_valid), 0);
    @(negedge clk_sys);
    chk("lat_n5", int'(b1.sample_valid), 1);
    chk("sat_l", int'(b1.audio_l), 32'h07FF);
    chk("sat_r", int'(b1.audio_r), 32'h07FF);
    @(negedge clk_sys);
    chk("lat_late", int'(b1.sample_valid), 0);
    idle(2);

    // mute holds midscale
    do_reset();
    for (int i = 0; i < 32; i++) begin
      strobe(16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
      idle(1);
    end
    idle(6);
    chk("mute_l", int'(b1.audio_l), 0);
    chk("mute_r", int'(b1.audio_r), 0);
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      strobe(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      idle(5);
`ifndef AUDIO_POST_MIX_DCBLOCK_EN
      chk("ramp_mono",
          int'(int'(b1.audio_l) <= prev), 1);
`endif
      prev = int'(b1.audio_l);
    end
    chk("ramp_neg", int'(int'(b1.audio_l) < 0), 1);

    // decimation by 16
    do_reset();
    base = n16;
    for (int i = 0; i < 64; i++) begin
      rnd_strobe(1'b0);
      idle(3);
    end
    idle(8);
    chk("d16_pulses", n16 - base, 4);
    chk("d16_drain", q16.size(), 0);

    // random back-to-back traffic
    for (int i = 0; i < 200; i++) begin
      rnd_strobe(($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 3));
    end
    idle(8);
    chk("rnd_drain1", q1.size(), 0);
    chk("rnd_drain16", q16.size(), 0);

    // reset while a sample is in flight
    base = n1;
    strobe(16'h9000, 16'h1234, 16'h0F00, 16'hFFFF, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_l", int'(b1.audio_l), 0);
    chk("async_r", int'(b1.audio_r), 0);
    chk("async_l16", int'(b16.audio_l), 0);
    idle(2);
    reset_n = 1'b1;
    idle(10);
    chk("flight_drop", n1 - base, 0);

    // constant pcm 0x4000 long run
    do_reset();
    strobe(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b0);
    idle(5);
    chk("const_first_nz", int'(b1.audio_l != 0), 1);
    for (int i = 1; i < 8192; i++)
      strobe(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b0);
    idle(8);
`ifdef AUDIO_POST_MIX_DCBLOCK_EN
    d = int'(b1.audio_l);
    chk("dc_removed", int'(d < 512 && d > -512), 1);
`else
    d = int'(b1.audio_l) - 32'h4000;
    chk("lpf_settle", int'(d < 16 && d > -16), 1);
`endif
    chk("final_drain", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
